seq_pattern_gen: RTL and testbench

//   Serial bit-pattern transmitter, the generating end of the serial sequence-detect path.

---
 rtl/seq_pattern_gen.sv | 145 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern transmitter.
// Captures a PAT_W-bit pattern on start and shifts it out MSB-first, repeat_n
// times, with gap_n idle cycles between repeats. The output handshake is
// valid/ready: a bit is consumed only when out_valid && out_ready, and out_bit
// holds steady while the consumer stalls. All outputs are registered.
module seq_pattern_gen #(
  parameter int PAT_W = 5,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;       // captured pattern, used for reloads
  logic [PAT_W-1:0] shreg;       // bits still to send in this repeat, MSB next
  logic [IDX_W-1:0] bit_idx;     // index of the bit currently presented
  logic [REP_W-1:0] reps_left;   // repeats not yet completed, incl. current
  logic [GAP_W-1:0] gap_q;       // captured gap length
  logic [GAP_W-1:0] gap_cnt;     // idle cycles remaining in the current gap

  // Sequencer: state, datapath registers and registered outputs together.
  // NOTE: every assignment here is non-blocking so all registers update from
  // the same pre-edge values; mixing in blocking writes would make the result
  // depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with the state so a
      // restart after an abort never sees stale pattern or count values.
      state     <= IDLE;
      pat_q     <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      reps_left <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            pat_q     <= pattern;
            shreg     <= pattern;
            gap_q     <= gap_n;
            reps_left <= repeat_n;
            bit_idx   <= '0;
            busy      <= 1'b1;
            if (repeat_n == '0) begin
              // Nothing to send: report completion on the next cycle.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SHIFT;
              out_valid <= 1'b1;
              out_bit   <= pattern[PAT_W-1];
            end
          end
        end

        SHIFT: begin
          if (out_ready) begin
            if (bit_idx != LAST_IDX) begin
              // Advance to the next bit of this repeat.
              shreg   <= shreg << 1;
              bit_idx <= bit_idx + IDX_W'(1);
              out_bit <= shreg[PAT_W-2];
            end else begin
              // Last bit of a repeat accepted.
              reps_left <= reps_left - REP_W'(1);
              bit_idx   <= '0;
              if (reps_left == REP_W'(1)) begin
                state     <= DONE;
                out_valid <= 1'b0;
                out_bit   <= 1'b0;
                done      <= 1'b1;
              end else if (gap_q == '0) begin
                // Back-to-back repeat: reload without a bubble.
                shreg   <= pat_q;
                out_bit <= pat_q[PAT_W-1];
              end else begin
                state     <= GAP;
                gap_cnt   <= gap_q;
                out_valid <= 1'b0;
                out_bit   <= 1'b0;
              end
            end
          end
        end

        GAP: begin
          // Idle gap runs on its own clock count; out_ready has no effect.
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            state     <= SHIFT;
            shreg     <= pat_q;
            out_valid <= 1'b1;
            out_bit   <= pat_q[PAT_W-1];
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: directed and randomized requests checked
// against a stream-level reference model built from the pattern, repeat count
// and gap length.
module tb_seq_pattern_gen;

  localparam int PAT_W = 5;
  localparam int REP_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap_n;
  logic             out_ready;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  // Bits accepted from the DUT during the most recent run_stream call.
  logic rx_q[$];

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap_n    (gap_n),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exact cycle-by-cycle check with out_ready held high. Expected waveform
  // {valid, bit, busy, done} starts the cycle after start.
  task automatic run_ready1(input string name, input logic [PAT_W-1:0] pat,
                            input logic [REP_W-1:0] rep, input logic [GAP_W-1:0] gap,
                            input bit noise);
    logic [3:0] exp_q[$];
    logic [3:0] got;
    for (int r = 0; r < int'(rep); r++) begin
      for (int i = 0; i < PAT_W; i++) exp_q.push_back({1'b1, pat[PAT_W-1-i], 1'b1, 1'b0});
      if (r < int'(rep) - 1)
        for (int g = 0; g < int'(gap); g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);   // done pulse, still busy
    exp_q.push_back(4'b0000);   // back in idle
    start     = 1'b1;
    pattern   = pat;
    repeat_n  = rep;
    gap_n     = gap;
    out_ready = 1'b1;
    step();
    foreach (exp_q[k]) begin
      // Inputs change freely after capture; optionally re-request mid-stream.
      start    = noise && (k < 3);
      pattern  = PAT_W'($urandom);
      repeat_n = REP_W'($urandom);
      gap_n    = GAP_W'($urandom);
      got = {out_valid, out_bit, busy, done};
      checks++;
      if (got !== exp_q[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: valid/bit/busy/done got %b expected %b",
                 name, k + 1, got, exp_q[k]);
      end
      step();
    end
    start = 1'b0;
  endtask

  // Handshake-level check with a variable out_ready.
  // mode 0: ready 1,0,0,1 repeating; mode 1: random; otherwise always 1.
  task automatic run_stream(input string name, input logic [PAT_W-1:0] pat,
                            input logic [REP_W-1:0] rep, input logic [GAP_W-1:0] gap,
                            input int mode);
    logic exp_q[$];
    logic e;
    logic rdy;
    logic prev_bit = 1'b0;
    bit   prev_stall = 1'b0;
    bit   in_gap = 1'b0;
    bit   finished = 1'b0;
    int   gap_seen = 0;
    int   consumed = 0;
    rx_q.delete();
    for (int r = 0; r < int'(rep); r++)
      for (int i = 0; i < PAT_W; i++) exp_q.push_back(pat[PAT_W-1-i]);
    start     = 1'b1;
    pattern   = pat;
    repeat_n  = rep;
    gap_n     = gap;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      case (mode)
        0:       rdy = (c % 4 == 0) || (c % 4 == 3);
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      if (done) begin
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s done: %0d bits outstanding, valid=%b busy=%b, expected 0 outstanding, valid=0 busy=1",
                   name, exp_q.size(), out_valid, busy);
        end
        finished = 1'b1;
      end else if (!out_valid) begin
        checks++;
        if (out_bit !== 1'b0 || busy !== 1'b1 || !in_gap || prev_stall) begin
          errors++;
          $display("FAIL %s cycle %0d idle: bit=%b busy=%b in_gap=%0d stalled_before=%0d, expected bit=0 busy=1 only inside a gap",
                   name, c + 1, out_bit, busy, in_gap, prev_stall);
        end
        if (in_gap) gap_seen++;
        prev_stall = 1'b0;
      end else begin
        if (in_gap) begin
          checks++;
          if (gap_seen != int'(gap)) begin
            errors++;
            $display("FAIL %s gap length: got %0d idle cycles expected %0d", name, gap_seen, gap);
          end
          in_gap = 1'b0;
        end
        if (prev_stall) begin
          checks++;
          if (out_bit !== prev_bit) begin
            errors++;
            $display("FAIL %s stall hold cycle %0d: bit got %b expected %b", name, c + 1, out_bit, prev_bit);
          end
        end
        if (rdy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s extra bit %b after %0d bits, expected none", name, out_bit, consumed);
          end else begin
            e = exp_q.pop_front();
            if (out_bit !== e) begin
              errors++;
              $display("FAIL %s bit %0d: got %b expected %b", name, consumed, out_bit, e);
            end
          end
          rx_q.push_back(out_bit);
          consumed++;
          if (consumed % PAT_W == 0 && exp_q.size() != 0) begin
            in_gap   = 1'b1;
            gap_seen = 0;
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_bit   = out_bit;
        end
      end
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: no done within 2000 cycles, expected done", name);
    end else if ({out_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s after done: valid/busy/done got %b expected 000", name, {out_valid, busy, done});
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    pattern   = '0;
    repeat_n  = '0;
    gap_n     = '0;
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_bit !== 1'b0) begin errors++; $display("FAIL reset out_bit: got %b expected 0", out_bit); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    rst = 1'b0;
    step();
    checks++;
    if ({out_valid, out_bit, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL idle after reset: got %b expected 0000", {out_valid, out_bit, busy, done});
    end
  endtask

  task automatic test_basic();
    run_ready1("basic_10110", 5'b10110, 8'd1, 4'd0, 1'b0);
  endtask

  task automatic test_gap();
    run_ready1("gap_r3_g2", 5'b10110, 8'd3, 4'd2, 1'b0);
  endtask

  task automatic test_stall();
    run_stream("stall_toggle", 5'b10110, 8'd2, 4'd0, 0);
    run_stream("stall_toggle_gap", 5'b10110, 8'd2, 4'd3, 0);
    for (int i = 0; i < 4; i++)
      run_stream("stall_random", PAT_W'($urandom), REP_W'($urandom_range(1, 3)),
                 GAP_W'($urandom_range(0, 3)), 1);
  endtask

  task automatic test_zero_repeat();
    run_ready1("zero_repeat", 5'b10110, 8'd0, 4'd3, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_ready1("start_ignored", 5'b10110, 8'd2, 4'd1, 1'b1);
  endtask

  task automatic test_reset_mid();
    start     = 1'b1;
    pattern   = 5'b10110;
    repeat_n  = 8'd3;
    gap_n     = 4'd0;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({out_valid, out_bit, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: valid/bit/busy/done got %b expected 0000", {out_valid, out_bit, busy, done});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid after %0d cycles: valid/busy/done got %b expected 000",
                 i + 1, {out_valid, busy, done});
      end
    end
    run_ready1("restart_after_reset", 5'b01101, 8'd2, 4'd1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_ready1("random_ready1", PAT_W'($urandom), REP_W'($urandom_range(1, 4)),
                 GAP_W'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_boundary();
    run_ready1("gap_max", 5'b11111, 8'd2, 4'd15, 1'b0);
    run_ready1("all_zero_pattern", 5'b00000, 8'd2, 4'd1, 1'b0);
    run_ready1("single_gap", 5'b10001, 8'd3, 4'd1, 1'b0);
  endtask

  // Loopback: feed accepted bits to a 10110 detector and compare its hit count
  // with the count found in the ideal stream.
  task automatic test_loopback();
    logic [PAT_W-1:0] pats[4];
    logic [PAT_W-1:0] win;
    logic             ideal[$];
    int               hits;
    int               ref_hits;
    pats[0] = 5'b10110;
    pats[1] = 5'b01101;
    pats[2] = PAT_W'($urandom);
    pats[3] = PAT_W'($urandom);
    for (int p = 0; p < 4; p++) begin
      run_stream("loopback", pats[p], 8'd2, 4'd0, (p < 2) ? 2 : 1);
      ideal.delete();
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < PAT_W; i++) ideal.push_back(pats[p][PAT_W-1-i]);
      ref_hits = 0;
      for (int i = 0; i + 5 <= ideal.size(); i++)
        if (ideal[i] == 1'b1 && ideal[i+1] == 1'b0 && ideal[i+2] == 1'b1 &&
            ideal[i+3] == 1'b1 && ideal[i+4] == 1'b0)
          ref_hits++;
      hits = 0;
      win  = '0;
      foreach (rx_q[i]) begin
        win = {win[PAT_W-2:0], rx_q[i]};
        if (i >= 4 && win == 5'b10110) hits++;
      end
      checks++;
      if (hits != ref_hits || rx_q.size() != ideal.size()) begin
        errors++;
        $display("FAIL loopback pattern %b: detector hits %0d over %0d bits, expected %0d over %0d",
                 pats[p], hits, rx_q.size(), ref_hits, ideal.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_stall();
    test_zero_repeat();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_boundary();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
